// File: rtl/pc_seq_if.sv
// Request/status bundle between the decode/control side and pc_sequencer.
// Handshake: no valid/ready pair; every request is a single-cycle level sampled at the rising clk edge, and it is ignored whenever stall is high.
interface pc_seq_if;
  logic        stall;
  logic        jump_req;
  logic [27:0] jump_field;
  logic        branch_req;
  logic [15:0] branch_off;
  logic        jr_req;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        redirect;
  logic        misalign_err;
  logic        slot_err;
  logic        state_dbg;

  modport master (
    output stall, jump_req, jump_field, branch_req, branch_off, jr_req, jr_target,
    input  pc, pc4, redirect, misalign_err, slot_err, state_dbg
  );

  modport slave (
    input  stall, jump_req, jump_field, branch_req, branch_off, jr_req, jr_target,
    output pc, pc4, redirect, misalign_err, slot_err, state_dbg
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, forms PC+4 and selects jump/branch/JR/sequential next PC.
// Optional MIPS branch delay slot when macro PC_DELAY_SLOT_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_seq_if.slave     bus
);

  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic [31:0] jump_tgt, branch_tgt, jr_tgt, req_tgt;
  logic        any_req;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;
`ifdef PC_DELAY_SLOT_EN
  logic [31:0] pend_q, pend_d;
  logic        slot_err_q, slot_err_d;
`endif

  // Target arithmetic always uses pc4 of the instruction currently at pc.
  always_comb begin
    pc4        = pc_q + 32'd4;
    jump_tgt   = {pc4[31:28], bus.jump_field};
    branch_tgt = pc4 + {{14{bus.branch_off[15]}}, bus.branch_off, 2'b00};
    jr_tgt     = {bus.jr_target[31:2], 2'b00};
    any_req    = bus.jr_req | bus.jump_req | bus.branch_req;
    if (bus.jr_req)          req_tgt = jr_tgt;
    else if (bus.jump_req)   req_tgt = jump_tgt;
    else if (bus.branch_req) req_tgt = branch_tgt;
    else                     req_tgt = pc4;
  end

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
`ifdef PC_DELAY_SLOT_EN
    pend_d     = pend_q;
    slot_err_d = 1'b0;
`endif
    if (!bus.stall) begin
      case (state_q)
        RUN: begin
          if (any_req) begin
`ifdef PC_DELAY_SLOT_EN
            pc_d    = pc4;
            pend_d  = req_tgt;
            state_d = SLOT;
`else
            pc_d       = req_tgt;
            redirect_d = 1'b1;
`endif
            misalign_d = bus.jr_req & (|bus.jr_target[1:0]);
          end else begin
            pc_d = pc4;
          end
        end
`ifdef PC_DELAY_SLOT_EN
        SLOT: begin
          // The delay-slot instruction may not itself redirect.
          pc_d       = pend_q;
          redirect_d = 1'b1;
          slot_err_d = any_req;
          state_d    = RUN;
        end
`endif
        default: begin
          pc_d    = pc4;
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      state_q    <= RUN;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_DELAY_SLOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 32'h0000_0000;
      slot_err_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      slot_err_q <= slot_err_d;
    end
  end
  assign bus.slot_err = slot_err_q;
`else
  assign bus.slot_err = 1'b0;
`endif

  assign bus.pc           = pc_q;
  assign bus.pc4          = pc4;
  assign bus.redirect     = redirect_q;
  assign bus.misalign_err = misalign_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle core: the consumer of the composed jump address. Each clock it owns the architectural PC, forms PC+4, and selects the next PC from sequential flow, a J-type target (28-bit shifted field joined with PC+4[31:28]), a PC-relative branch, or a register jump. It feeds instruction-memory addressing and hands PC+4 back to the jump-address composer and link-register writeback.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and all internal state this cycle.
- jump_req  in  1  J/JAL taken this cycle.
- jump_field  in  28  instr[25:0]<<2, low two bits always 0.
- branch_req  in  1  conditional branch taken this cycle.
- branch_off  in  16  signed word offset (instr[15:0]).
- jr_req  in  1  JR/JALR taken this cycle.
- jr_target  in  32  register value for JR/JALR.
- pc  out  32  current PC (registered).
- pc4  out  32  pc + 4 (combinational from pc).
- redirect  out  1  registered; 1 for the cycle after the PC was loaded with a non-sequential target.
- misalign_err  out  1  registered; 1 for one cycle when a JR target had bits [1:0] != 0.
- slot_err  out  1  registered; see Configuration.

## Operation
- Reset (rst_n low, asynchronous): pc = RESET_PC, redirect = 0, misalign_err = 0, slot_err = 0, internal state = RUN, pending target cleared.
- Target arithmetic: jump = {pc4[31:28], jump_field}; branch = pc4 + ({{14{branch_off[15]}}, branch_off, 2'b00}) modulo 2^32; jr = {jr_target[31:2], 2'b00}. pc4 wraps 32'hFFFF_FFFC -> 0.
- Priority when several requests are high: jr_req > jump_req > branch_req > sequential.
- stall = 1: pc, state, pending target hold; redirect, misalign_err, slot_err go 0; all requests ignored.
- misalign_err set only when the JR is actually accepted (not stalled, not ignored).
- States: RUN (normal), SLOT (DELAY_SLOT_EN only; one delayed redirect pending).
- Without DELAY_SLOT_EN: only RUN is used; an accepted request loads its target into pc at the next edge.

## Timing
- Next-PC selection combinational; pc updates on the rising edge of clk when stall = 0.
- Latency request -> pc = target: 1 edge (no delay slot), 2 edges (delay slot).
- redirect asserted the cycle in which pc first shows the non-sequential target, deasserted next cycle unless another redirect occurs.
- Reset deassertion mid-operation: first edge with rst_n high and stall = 0 advances from RESET_PC; a pending SLOT target is lost on reset.
- Back-to-back taken jumps (no delay slot) each take effect on consecutive edges; redirect stays high.

## Configuration
- Macro PC_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. Accepted request in RUN: pc <- pc4, target latched, state -> SLOT. In SLOT (not stalled): pc <- latched target, redirect = 1 next cycle, state -> RUN. Any request seen in SLOT is ignored and slot_err pulses 1 for one cycle. Target arithmetic uses pc4 of the requesting instruction.
- Undefined: SLOT state and latch are not built; slot_err tied 0; redirect immediate as in Operation.

## Test plan
- Reset with RESET_PC=32'h0040_0000, release, 3 free-running cycles -> pc = 0x00400000, 0x00400004, 0x00400008; all flags 0.
- pc=0x10000008, jump_req with jump_field=28'h0000_100 -> next pc = 0x10000100, redirect = 1 one cycle.
- pc=0x00000020, branch_off=16'hFFFC -> next pc = 0x00000014; with jr_req also high and jr_target=0x0000_0200 -> next pc = 0x00000200 (priority).
- jr_target=0x0000_0103 -> pc = 0x00000100, misalign_err = 1 for exactly one cycle; same request under stall -> pc holds, misalign_err 0.
- PC_DELAY_SLOT_EN: pc=0x100, jump to field 0x400 -> pc 0x104 then 0x400; branch request during 0x104 -> ignored, slot_err = 1; stall during SLOT holds pc 0x104 and pending target.
- rst_n dropped asynchronously mid-cycle while in SLOT -> pc = RESET_PC immediately, pending target discarded, sequential flow after release.
